bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master arbiter (instruction fetch, data access) onto one registered memory port, with wait timeout.
// Optional macro BUS_ARB_RR_EN: round-robin between the two masters on contention (default build: data has priority).
module bus_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stall_o,
    output logic        err_o
);

    // state | meaning
    // IDLE  | bus free, arbitrate between eligible requesters
    // GNT_I | fetch owns the bus, waiting for bus_ack_i or timeout
    // GNT_D | data access owns the bus, waiting for bus_ack_i or timeout
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       if_elig, mem_elig, pick_data;
    logic       grant_d, grant_i, done, abort;

    // A requester whose ack is high this cycle is still holding req; mask it.
    assign if_elig  = if_req_i & ~if_ack_o;
    assign mem_elig = mem_req_i & ~mem_ack_o;
    assign stall_o  = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

`ifdef BUS_ARB_RR_EN
    logic last_fetch;
    assign pick_data = last_fetch;
`else
    assign pick_data = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_elig && (!if_elig || pick_data)) begin
                    grant_d   = 1'b1;
                    state_nxt = GNT_D;
                end else if (if_elig) begin
                    grant_i   = 1'b1;
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (bus_ack_i) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt    <= 8'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'd0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            err_o       <= 1'b0;
            if_rdata_o  <= 32'd0;
            mem_rdata_o <= 32'd0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            err_o     <= 1'b0;
            if (grant_d) begin
                wait_cnt    <= 8'd0;
                bus_req_o   <= 1'b1;
                bus_we_o    <= mem_we_i;
                bus_sel_o   <= mem_sel_i;
                bus_addr_o  <= mem_addr_i;
                bus_wdata_o <= mem_wdata_i;
            end else if (grant_i) begin
                wait_cnt    <= 8'd0;
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= 4'hF;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= 32'd0;
            end else if (done || abort) begin
                bus_req_o <= 1'b0;
                err_o     <= abort;
                if (state == GNT_D) begin
                    mem_ack_o   <= 1'b1;
                    mem_rdata_o <= done ? bus_rdata_i : 32'd0;
                end else begin
                    if_ack_o   <= 1'b1;
                    if_rdata_o <= done ? bus_rdata_i : 32'd0;
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

`ifdef BUS_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_fetch <= 1'b1;
        end else if (done || abort) begin
            last_fetch <= (state == GNT_I);
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT = 64).
module tb_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stall_o;
    logic        err_o;

    int checks = 0;
    int passed = 0;

    bus_arbiter #(.TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'd0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_sel_i = 4'd0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0; bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
        tick(); tick();
        checks++;
        if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, if_ack_o, mem_ack_o, err_o,
             if_rdata_o, mem_rdata_o} !== '0)
            $display("FAIL reset_outputs: got req=%b ack=%b/%b err=%b addr=%h, required all zero",
                     bus_req_o, if_ack_o, mem_ack_o, err_o, bus_addr_o);
        else passed++;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_idle_ack_ignored();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        tick(); tick();
        checks++;
        if ({bus_req_o, if_ack_o, mem_ack_o, err_o} !== 4'b0)
            $display("FAIL idle_ack: got req=%b if_ack=%b mem_ack=%b err=%b, required 0000",
                     bus_req_o, if_ack_o, mem_ack_o, err_o);
        else passed++;
        bus_ack_i = 1'b0;
    endtask

    task automatic test_fetch_min_latency();
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        #1;
        checks++;
        if (stall_o !== 1'b1) $display("FAIL fetch_stall_n: got %b required 1", stall_o);
        else passed++;
        tick();
        checks++;
        if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h10, 32'h0})
            $display("FAIL fetch_grant: got req=%b we=%b sel=%h addr=%h wdata=%h, required 1 0 f 00000010 0",
                     bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
        else passed++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0005;
        #1;
        checks++;
        if (stall_o !== 1'b1) $display("FAIL fetch_stall_n1: got %b required 1", stall_o);
        else passed++;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        #1;
        checks++;
        if ({if_ack_o, mem_ack_o, err_o, bus_req_o, stall_o} !== 5'b10000 || if_rdata_o !== 32'h2402_0005)
            $display("FAIL fetch_ack: got ack=%b mack=%b err=%b req=%b stall=%b rdata=%h, required 1 0 0 0 0 24020005",
                     if_ack_o, mem_ack_o, err_o, bus_req_o, stall_o, if_rdata_o);
        else passed++;
        if_req_i = 1'b0;
        tick();
        checks++;
        if ({if_ack_o, bus_req_o} !== 2'b00 || if_rdata_o !== 32'h2402_0005)
            $display("FAIL fetch_hold: got ack=%b req=%b rdata=%h, required 0 0 24020005",
                     if_ack_o, bus_req_o, if_rdata_o);
        else passed++;
    endtask

    task automatic test_contention();
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h0000_0100;
        mem_wdata_i = 32'hCAFE_0001; if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
        tick();
        checks++;
        if (bus_addr_o !== 32'h100 || bus_we_o !== 1'b1 || bus_req_o !== 1'b1)
            $display("FAIL contend_data_first: got addr=%h we=%b req=%b, required 00000100 1 1",
                     bus_addr_o, bus_we_o, bus_req_o);
        else passed++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_00AA;
        tick();
        bus_ack_i = 1'b0;
        checks++;
        if ({mem_ack_o, if_ack_o, bus_req_o} !== 3'b100 || mem_rdata_o !== 32'hAA)
            $display("FAIL contend_mem_ack: got mack=%b iack=%b req=%b rdata=%h, required 1 0 0 000000aa",
                     mem_ack_o, if_ack_o, bus_req_o, mem_rdata_o);
        else passed++;
        mem_req_i = 1'b0;
        tick();
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h20 || bus_we_o !== 1'b0)
            $display("FAIL contend_fetch_next: got req=%b addr=%h we=%b, required 1 00000020 0",
                     bus_req_o, bus_addr_o, bus_we_o);
        else passed++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_00BB;
        tick();
        bus_ack_i = 1'b0;
        if_req_i = 1'b0;
        checks++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hBB)
            $display("FAIL contend_fetch_ack: got ack=%b rdata=%h, required 1 000000bb", if_ack_o, if_rdata_o);
        else passed++;
        tick();
        // data-only transfer, then contention: the default build favours data, round-robin favours fetch
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0200;
        tick();
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0300; if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        tick();
        checks++;
`ifdef BUS_ARB_RR_EN
        if (bus_addr_o !== 32'h40)
            $display("FAIL contend_second: got addr=%h, required 00000040", bus_addr_o);
        else passed++;
`else
        if (bus_addr_o !== 32'h300)
            $display("FAIL contend_second: got addr=%h, required 00000300", bus_addr_o);
        else passed++;
`endif
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        if (mem_ack_o) mem_req_i = 1'b0;
        if (if_ack_o) if_req_i = 1'b0;
        tick();
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0; mem_req_i = 1'b0; if_req_i = 1'b0;
        tick();
        checks++;
        if ({bus_req_o, if_ack_o, mem_ack_o} !== 3'b000)
            $display("FAIL contend_drain: got req=%b iack=%b mack=%b, required 000", bus_req_o, if_ack_o, mem_ack_o);
        else passed++;
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h0000_0400;
        mem_wdata_i = 32'h1234_5678; bus_rdata_i = 32'h5555_5555;
        tick();
        checks++;
        if (bus_wdata_o !== 32'h1234_5678 || bus_sel_o !== 4'b0011 || bus_we_o !== 1'b1)
            $display("FAIL timeout_grant: got wdata=%h sel=%b we=%b, required 12345678 0011 1",
                     bus_wdata_o, bus_sel_o, bus_we_o);
        else passed++;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (mem_ack_o || err_o || !bus_req_o) early++;
        end
        checks++;
        if (early != 0) $display("FAIL timeout_early: got %0d bad cycles, required 0", early);
        else passed++;
        tick();
        checks++;
        if ({mem_ack_o, err_o, bus_req_o, if_ack_o} !== 4'b1100 || mem_rdata_o !== 32'd0)
            $display("FAIL timeout_abort: got ack=%b err=%b req=%b iack=%b rdata=%h, required 1 1 0 0 0",
                     mem_ack_o, err_o, bus_req_o, if_ack_o, mem_rdata_o);
        else passed++;
        mem_req_i = 1'b0;
        tick();
        checks++;
        if ({mem_ack_o, err_o} !== 2'b00)
            $display("FAIL timeout_pulse: got ack=%b err=%b, required 0 0", mem_ack_o, err_o);
        else passed++;
    endtask

    task automatic test_timeout_boundary();
        if_req_i = 1'b1; if_addr_i = 32'h0000_0080; bus_rdata_i = 32'h0BAD_F00D;
        tick();
        for (int i = 0; i < 63; i++) tick();
        checks++;
        if (bus_req_o !== 1'b1 || if_ack_o !== 1'b0)
            $display("FAIL boundary_wait: got req=%b ack=%b, required 1 0", bus_req_o, if_ack_o);
        else passed++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0600_D001;
        tick();
        bus_ack_i = 1'b0;
        checks++;
        if ({if_ack_o, err_o, bus_req_o} !== 3'b100 || if_rdata_o !== 32'h0600_D001)
            $display("FAIL boundary_ack: got ack=%b err=%b req=%b rdata=%h, required 1 0 0 0600d001",
                     if_ack_o, err_o, bus_req_o, if_rdata_o);
        else passed++;
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        if_req_i = 1'b1; if_addr_i = 32'h0000_00C0;
        tick();
        checks++;
        if (bus_req_o !== 1'b1) $display("FAIL rst_mid_grant: got req=%b required 1", bus_req_o);
        else passed++;
        rst_i = 1'b1;
        tick();
        checks++;
        if ({bus_req_o, if_ack_o, err_o} !== 3'b000 || bus_addr_o !== 32'd0 || if_rdata_o !== 32'd0)
            $display("FAIL rst_mid_abort: got req=%b ack=%b err=%b addr=%h rdata=%h, required all zero",
                     bus_req_o, if_ack_o, err_o, bus_addr_o, if_rdata_o);
        else passed++;
        rst_i = 1'b0;
        tick();
        checks++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'hC0 || if_ack_o !== 1'b0)
            $display("FAIL rst_regrant: got req=%b addr=%h ack=%b, required 1 000000c0 0",
                     bus_req_o, bus_addr_o, if_ack_o);
        else passed++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0C0C;
        tick();
        bus_ack_i = 1'b0;
        checks++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h0C0C)
            $display("FAIL rst_regrant_ack: got ack=%b rdata=%h, required 1 00000c0c", if_ack_o, if_rdata_o);
        else passed++;
        if_req_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_ack_ignored();
        test_fetch_min_latency();
        test_contention();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
